// File: rtl/unidade_controle_pkg.sv
// unidade_controle_pkg: state, ALU op, opcode and mux-select encodings plus instruction decode helpers
package unidade_controle_pkg;
  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH_WAIT, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ADDR, ST_MEM_RD,
    ST_MEM_RD_WAIT, ST_WB_LOAD, ST_MEM_WR, ST_WB_ALU, ST_BRANCH, ST_JAL, ST_LUI, ST_ILLEGAL
  } state_t;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_LD_ST = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;
  typedef struct packed {
    logic       legal;
    logic [2:0] op;
  } alu_dec_t;
  function automatic state_t dispatch(input logic [6:0] opc);
    case (opc)
      OPC_R:               return ST_EXEC_R;
      OPC_I:               return ST_EXEC_I;
      OPC_LOAD, OPC_STORE: return ST_ADDR;
      OPC_BRANCH:          return ST_BRANCH;
      OPC_JAL:             return ST_JAL;
      OPC_LUI:             return ST_LUI;
      default:             return ST_ILLEGAL;
    endcase
  endfunction
  function automatic alu_dec_t r_decode(input logic [2:0] f3, input logic f7);
    alu_dec_t d;
    d.legal = (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_XOR);
    d.op = (f3 == F3_ADD) ? (f7 ? OP_SUB : OP_ADD) :
           (f3 == F3_AND) ? OP_AND :
           (f3 == F3_XOR) ? OP_XOR : OP_PASS;
    return d;
  endfunction
endpackage

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle RISC-V subset control FSM driving datapath strobes and mux selects
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       reset_wire,
  output logic [2:0] operacao,
  output logic       WRITE_PC,
  output logic       PC_SRC,
  output logic       WRITE_INSTRUCTION,
  output logic       LOAD_OLDPC,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_ALUOUT,
  output logic       LOAD_MDR,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic       DMEM_RD,
  output logic       DMEM_WR,
  output logic       WRITE_REG,
  output logic [1:0] MEM_TO_REG,
  output logic       ILLEGAL,
  output logic [3:0] estado_out
);
  state_t state_q, state_d;
  alu_dec_t r_dec;
  assign r_dec = r_decode(funct3, funct7_5);
  assign estado_out = state_q;
  always_ff @(posedge CLK) state_q <= RST ? ST_RESET : state_d;
  always_comb begin
    state_d = state_q;
    reset_wire = 1'b0;
    operacao = OP_PASS;
    WRITE_PC = 1'b0;
    PC_SRC = 1'b0;
    WRITE_INSTRUCTION = 1'b0;
    LOAD_OLDPC = 1'b0;
    LOAD_A = 1'b0;
    LOAD_B = 1'b0;
    LOAD_ALUOUT = 1'b0;
    LOAD_MDR = 1'b0;
    ALU_SRC_A = SRCA_PC;
    ALU_SRC_B = SRCB_B;
    DMEM_RD = 1'b0;
    DMEM_WR = 1'b0;
    WRITE_REG = 1'b0;
    MEM_TO_REG = M2R_ALUOUT;
    ILLEGAL = 1'b0;
    case (state_q)
      ST_RESET: begin
        reset_wire = 1'b1;
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: state_d = ST_FETCH;
      ST_FETCH: begin
        ALU_SRC_B = SRCB_4;
        operacao = OP_ADD;
        WRITE_PC = 1'b1;
        WRITE_INSTRUCTION = 1'b1;
        LOAD_OLDPC = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        LOAD_A = 1'b1;
        LOAD_B = 1'b1;
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_IMM;
        operacao = OP_ADD;
        LOAD_ALUOUT = 1'b1;
        state_d = dispatch(opcode);
      end
      ST_EXEC_R: begin
        ALU_SRC_A = SRCA_A;
        operacao = r_dec.op;
        LOAD_ALUOUT = 1'b1;
        state_d = r_dec.legal ? ST_WB_ALU : ST_ILLEGAL;
      end
      ST_EXEC_I: begin
        ALU_SRC_A = SRCA_A;
        ALU_SRC_B = SRCB_IMM;
        operacao = OP_ADD;
        LOAD_ALUOUT = 1'b1;
        state_d = (funct3 == F3_ADD) ? ST_WB_ALU : ST_ILLEGAL;
      end
      ST_ADDR: begin
        ALU_SRC_A = SRCA_A;
        ALU_SRC_B = SRCB_IMM;
        operacao = OP_ADD;
        LOAD_ALUOUT = 1'b1;
        state_d = (funct3 != F3_LD_ST) ? ST_ILLEGAL :
                  (opcode == OPC_LOAD) ? ST_MEM_RD :
                  (opcode == OPC_STORE) ? ST_MEM_WR : ST_ILLEGAL;
      end
      ST_MEM_RD: begin
        DMEM_RD = 1'b1;
        state_d = ST_MEM_RD_WAIT;
      end
      ST_MEM_RD_WAIT: begin
        DMEM_RD = 1'b1;
        LOAD_MDR = 1'b1;
        state_d = ST_WB_LOAD;
      end
      ST_WB_LOAD: begin
        WRITE_REG = 1'b1;
        MEM_TO_REG = M2R_MDR;
        state_d = ST_FETCH_WAIT;
      end
      ST_MEM_WR: begin
        DMEM_WR = 1'b1;
        state_d = ST_FETCH_WAIT;
      end
      ST_WB_ALU: begin
        WRITE_REG = 1'b1;
        state_d = ST_FETCH_WAIT;
      end
      ST_BRANCH: begin
        ALU_SRC_A = SRCA_A;
        operacao = OP_SUB;
        PC_SRC = 1'b1;
        WRITE_PC = (funct3 == F3_BEQ) ? zero : (funct3 == F3_BNE) ? ~zero : 1'b0;
        state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? ST_FETCH_WAIT : ST_ILLEGAL;
      end
      ST_JAL: begin
        WRITE_REG = 1'b1;
        MEM_TO_REG = M2R_PC;
        WRITE_PC = 1'b1;
        PC_SRC = 1'b1;
        state_d = ST_FETCH_WAIT;
      end
      ST_LUI: begin
        ALU_SRC_A = SRCA_ZERO;
        ALU_SRC_B = SRCB_IMM;
        operacao = OP_ADD;
        LOAD_ALUOUT = 1'b1;
        state_d = ST_WB_ALU;
      end
      ST_ILLEGAL: ILLEGAL = 1'b1;
      default: state_d = ST_RESET;
    endcase
  end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed instruction sequences with a per-cycle expected-output scoreboard
module tb_unidade_controle;
  logic CLK = 1'b0, RST = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, zero = 1'b0;
  logic reset_wire, WRITE_PC, PC_SRC, WRITE_INSTRUCTION, LOAD_OLDPC, LOAD_A, LOAD_B;
  logic LOAD_ALUOUT, LOAD_MDR, DMEM_RD, DMEM_WR, WRITE_REG, ILLEGAL;
  logic [2:0] operacao;
  logic [1:0] ALU_SRC_A, ALU_SRC_B, MEM_TO_REG;
  logic [3:0] estado_out;
  typedef struct packed {
    logic rw; logic [2:0] op;
    logic wpc, pcs, wi, lo, la, lb, lalu, lmdr;
    logic [1:0] sa, sb;
    logic drd, dwr, wr;
    logic [1:0] m2r;
    logic ill;
    logic [3:0] st;
  } out_t;
  out_t got;
  out_t exp_q[$];
  int tests = 0, fails = 0;
  string tag = "reset";
  unidade_controle dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .reset_wire(reset_wire), .operacao(operacao), .WRITE_PC(WRITE_PC), .PC_SRC(PC_SRC),
    .WRITE_INSTRUCTION(WRITE_INSTRUCTION), .LOAD_OLDPC(LOAD_OLDPC), .LOAD_A(LOAD_A),
    .LOAD_B(LOAD_B), .LOAD_ALUOUT(LOAD_ALUOUT), .LOAD_MDR(LOAD_MDR), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .DMEM_RD(DMEM_RD), .DMEM_WR(DMEM_WR), .WRITE_REG(WRITE_REG),
    .MEM_TO_REG(MEM_TO_REG), .ILLEGAL(ILLEGAL), .estado_out(estado_out)
  );
  assign got = {reset_wire, operacao, WRITE_PC, PC_SRC, WRITE_INSTRUCTION, LOAD_OLDPC, LOAD_A,
                LOAD_B, LOAD_ALUOUT, LOAD_MDR, ALU_SRC_A, ALU_SRC_B, DMEM_RD, DMEM_WR,
                WRITE_REG, MEM_TO_REG, ILLEGAL, estado_out};
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      out_t e;
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: state %0d outputs got=%h expected=%h (state %0d)", tag, got.st, got, e, e.st);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  function automatic out_t s(input logic [3:0] st);
    out_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction
  task automatic cyc(input out_t e);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic front(input string t, input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    out_t e;
    tag = t; opcode = o; funct3 = f3; funct7_5 = f7; zero = z;
    cyc(s(1));
    e = s(2); e.op = 3'b001; e.sb = 2'b01; e.wpc = 1; e.wi = 1; e.lo = 1;
    cyc(e);
    e = s(3); e.la = 1; e.lb = 1; e.sa = 2'b10; e.sb = 2'b10; e.op = 3'b001; e.lalu = 1;
    cyc(e);
  endtask
  task automatic wb_alu();
    out_t e;
    e = s(11); e.wr = 1;
    cyc(e);
  endtask
  task automatic r_type(input string t, input logic [2:0] f3, input logic f7, input logic [2:0] op);
    out_t e;
    front(t, 7'b0110011, f3, f7, 1'b0);
    e = s(4); e.sa = 2'b01; e.op = op; e.lalu = 1;
    cyc(e);
    wb_alu();
  endtask
  function automatic out_t addr_e();
    out_t e;
    e = s(6); e.sa = 2'b01; e.sb = 2'b10; e.op = 3'b001; e.lalu = 1;
    return e;
  endfunction
  function automatic out_t ill_e();
    out_t e;
    e = s(15); e.ill = 1;
    return e;
  endfunction
  function automatic out_t rst_e();
    out_t e;
    e = s(0); e.rw = 1;
    return e;
  endfunction
  task automatic branch(input string t, input logic [2:0] f3, input logic z, input logic wpc);
    out_t e;
    front(t, 7'b1100011, f3, 1'b0, z);
    e = s(12); e.sa = 2'b01; e.op = 3'b010; e.pcs = 1; e.wpc = wpc;
    cyc(e);
  endtask
  task automatic hold_ill_then_reset(input int n);
    for (int i = 0; i < n - 1; i++) cyc(ill_e());
    RST = 1;
    cyc(ill_e());
    RST = 0;
    cyc(rst_e());
  endtask
  initial begin
    out_t e;
    @(posedge CLK);
    #1;
    cyc(rst_e());
    RST = 0;
    cyc(rst_e());
    r_type("r_sub", 3'b000, 1'b1, 3'b010);
    r_type("r_add", 3'b000, 1'b0, 3'b001);
    r_type("r_and", 3'b111, 1'b1, 3'b011);
    r_type("r_xor", 3'b100, 1'b0, 3'b110);
    front("addi", 7'b0010011, 3'b000, 1'b0, 1'b0);
    e = s(5); e.sa = 2'b01; e.sb = 2'b10; e.op = 3'b001; e.lalu = 1;
    cyc(e);
    wb_alu();
    front("lui", 7'b0110111, 3'b101, 1'b0, 1'b0);
    e = s(14); e.sa = 2'b11; e.sb = 2'b10; e.op = 3'b001; e.lalu = 1;
    cyc(e);
    wb_alu();
    front("load", 7'b0000011, 3'b011, 1'b0, 1'b0);
    cyc(addr_e());
    e = s(7); e.drd = 1;
    cyc(e);
    e = s(8); e.drd = 1; e.lmdr = 1;
    cyc(e);
    e = s(9); e.wr = 1; e.m2r = 2'b01;
    cyc(e);
    front("store", 7'b0100011, 3'b011, 1'b0, 1'b0);
    cyc(addr_e());
    e = s(10); e.dwr = 1;
    cyc(e);
    branch("beq_z1", 3'b000, 1'b1, 1'b1);
    branch("bne_z1", 3'b001, 1'b1, 1'b0);
    branch("beq_z0", 3'b000, 1'b0, 1'b0);
    branch("bne_z0", 3'b001, 1'b0, 1'b1);
    front("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
    e = s(13); e.wr = 1; e.m2r = 2'b10; e.wpc = 1; e.pcs = 1;
    cyc(e);
    branch("bad_branch", 3'b010, 1'b1, 1'b0);
    hold_ill_then_reset(3);
    front("bad_load_f3", 7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc(addr_e());
    hold_ill_then_reset(2);
    front("bad_opcode", 7'b1111111, 3'b000, 1'b0, 1'b0);
    hold_ill_then_reset(10);
    front("load_rst", 7'b0000011, 3'b011, 1'b0, 1'b0);
    cyc(addr_e());
    e = s(7); e.drd = 1;
    cyc(e);
    RST = 1;
    e = s(8); e.drd = 1; e.lmdr = 1;
    cyc(e);
    RST = 0;
    cyc(rst_e());
    r_type("after_rst", 3'b000, 1'b0, 3'b001);
    tag = "tail";
    cyc(s(1));
    @(negedge CLK);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
